alu_seq: RTL



---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/alu_seq_muldiv.sv | 90 +++++++++
 rtl/alu_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: 4-bit opcode encodings, controller states
// and the flag helper used for single-cycle results.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } flags_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_REMU;
  endfunction

  // Overflow is judged from sign bits only; SUB treats b as negated, so its
  // overflow condition is the mirror of ADD's.
  function automatic flags_t calc_flags(input logic       res_zero,
                                        input logic [3:0] op,
                                        input logic       carry_out,
                                        input logic       a_msb,
                                        input logic       b_msb,
                                        input logic       r_msb);
    flags_t f;
    f = '0;
    f.zero = res_zero;
    case (op)
      OP_ADD: begin
        f.carry    = carry_out;
        f.overflow = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        f.carry    = carry_out;
        f.overflow = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_SLT, OP_SLTU: f.carry = carry_out;
      default: ;
    endcase
    if (!is_legal(op)) begin
      f.zero    = 1'b1;
      f.illegal = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide/remainder (restoring),
// one step per cycle for WIDTH cycles; the final step's result is presented combinationally.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    count;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;

  // A zero divisor never makes the trial negative, which yields the all-ones
  // quotient and a remainder equal to the dividend without special casing.
  always_comb begin
    acc_next  = mplier[0] ? (acc + mcand) : acc;
    shifted   = {rem, quo[WIDTH-1]};
    trial     = {1'b0, shifted} - {2'b00, divisor};
    trial_neg = |trial[WIDTH+1:WIDTH];
    if (trial_neg) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      count   <= '0;
      op_q    <= OP_AND;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= '0;
      op_q    <= op;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      rem     <= '0;
      quo     <= a;
      divisor <= b;
    end else if (busy) begin
      busy    <= (count != LAST);
      count   <= count + CW'(1);
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      rem     <= rem_next;
      quo     <= quo_next;
    end
  end

  assign done   = busy && (count == LAST);
  assign result = (op_q == OP_MUL)  ? acc_next :
                  (op_q == OP_DIVU) ? quo_next : rem_next;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops land in the output register at accept,
// MUL/DIVU/REMU go through alu_seq_muldiv; results hold until out_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             start_iter;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic             slt;
  logic             carry_out;
  logic [WIDTH-1:0] single_result;
  flags_t           single_flags;

  assign accept     = in_valid && in_ready;
  assign start_iter = accept && is_iterative(op);

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_iter),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  // SUB, SLT and SLTU share one a + ~b + 1 adder so their carry agrees.
  always_comb begin
    sum           = {1'b0, a} + {1'b0, b};
    diff          = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    shamt         = b[SHW-1:0];
    slt           = ($signed(a) < $signed(b));
    single_result = '0;
    case (op)
      OP_AND:  single_result = a & b;
      OP_OR:   single_result = a | b;
      OP_ADD:  single_result = sum[WIDTH-1:0];
      OP_XOR:  single_result = a ^ b;
      OP_SLL:  single_result = a << shamt;
      OP_SRL:  single_result = a >> shamt;
      OP_SUB:  single_result = diff[WIDTH-1:0];
      OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: single_result = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
      OP_SRA:  single_result = $signed(a) >>> shamt;
      default: single_result = '0;
    endcase
    carry_out    = (op == OP_ADD) ? sum[WIDTH] : diff[WIDTH];
    single_flags = calc_flags(single_result == '0, op, carry_out,
                              a[WIDTH-1], b[WIDTH-1], single_result[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // DONE with out_ready behaves like IDLE so back-to-back ops keep one per cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = is_iterative(op) ? BUSY : DONE;
      BUSY: if (md_done) state_next = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_next = is_iterative(op) ? BUSY : DONE;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !is_iterative(op)) begin
      result   <= single_result;
      zero     <= single_flags.zero;
      carry    <= single_flags.carry;
      overflow <= single_flags.overflow;
      illegal  <= single_flags.illegal;
    end else if ((state == BUSY) && md_done) begin
      result   <= md_result;
      zero     <= (md_result == '0);
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end
  end

endmodule
